// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and bus widths.
// Imported by AXI4-Lite initiators and targets in this slice.
package axi_lite_pkg;

    localparam int AXIL_DATA_WIDTH = 32;
    localparam int AXIL_STRB_WIDTH = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

endpackage

// File: rtl/axi_ads124x_axil_master.sv
// Single-outstanding AXI4-Lite initiator: one valid/ready command in,
// one AXI4-Lite write or read out, one response (data + resp) back.
// Ports: aclk/aresetn; cmd_* command stream; rsp_* response stream;
// m_axi_* AXI4-Lite master (32-bit data, ADDR_WIDTH address).
// A silent slave stalls this block forever; there is no timeout.
module axi_ads124x_axil_master
    import axi_lite_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                       aclk,
    input  logic                       aresetn,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr,
    input  logic [AXIL_DATA_WIDTH-1:0] cmd_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0] cmd_wstrb,

    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_write,
    output logic [AXIL_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                 rsp_resp,

    output logic [ADDR_WIDTH-1:0]      m_axi_awaddr,
    output logic [2:0]                 m_axi_awprot,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [AXIL_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [AXIL_STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [2:0]                 m_axi_arprot,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [AXIL_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RSP
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    state_t                       state_q;
    state_t                       state_d;

    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [AXIL_DATA_WIDTH-1:0]   wdata_q;
    logic [AXIL_STRB_WIDTH-1:0]   wstrb_q;
    logic                         write_q;
    logic [AXIL_DATA_WIDTH-1:0]   rdata_q;
    axi_resp_t                    resp_q;

    // AW and W complete independently; these remember which is done.
    logic                         aw_done_q;
    logic                         w_done_q;

    logic                         aw_hs;
    logic                         w_hs;
    logic                         aw_fin;
    logic                         w_fin;

    assign aw_hs  = m_axi_awvalid & m_axi_awready;
    assign w_hs   = m_axi_wvalid & m_axi_wready;
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = cmd_write ? S_WR_ADDR_DATA : S_RD_ADDR;
                end
            end
            S_WR_ADDR_DATA: begin
                if (aw_fin && w_fin) state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (m_axi_bvalid) state_d = S_RSP;
            end
            S_RD_ADDR: begin
                if (m_axi_arready) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (m_axi_rvalid) state_d = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: decoded from registered state only, so the async reset
    // drops every valid/ready without waiting for a clock edge.
    always_comb begin
        cmd_ready     = (state_q == S_IDLE);
        m_axi_awvalid = (state_q == S_WR_ADDR_DATA) && !aw_done_q;
        m_axi_wvalid  = (state_q == S_WR_ADDR_DATA) && !w_done_q;
        m_axi_bready  = (state_q == S_WR_RESP);
        m_axi_arvalid = (state_q == S_RD_ADDR);
        m_axi_rready  = (state_q == S_RD_DATA);
        rsp_valid     = (state_q == S_RSP);
    end

    // Capture registers; all AXI payloads come from here.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= OKAY;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr & WORD_MASK;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        write_q   <= cmd_write;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                S_WR_ADDR_DATA: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                end
                S_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        resp_q  <= axi_resp_t'(m_axi_bresp);
                        rdata_q <= '0;
                    end
                end
                S_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        resp_q  <= axi_resp_t'(m_axi_rresp);
                        rdata_q <= m_axi_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_awprot = PROT;
    assign m_axi_arprot = PROT;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;

    assign rsp_write = write_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

endmodule

// File: tb/tb_axi_ads124x_axil_master.sv
// Scoreboard bench for axi_ads124x_axil_master: a memory-backed AXI4-Lite
// slave with tunable ready/valid delays and an in-order response monitor.
module tb_axi_ads124x_axil_master;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;

    always #5 aclk = ~aclk;

    axi_ads124x_axil_master dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Slave rule: response code is address bits [9:8], word index [7:2].
    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return a[9:8];
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[7:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit rdy(input int lat, input int waitc);
        if (lat < 0) return 1'($urandom_range(0, 1));
        return waitc >= lat;
    endfunction

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    // Expectations, written only by the stimulus process.
    rsp_t        rsp_q[$];
    logic [31:0] aw_exp[$];
    logic [35:0] w_exp[$];
    logic [31:0] ar_exp[$];
    logic [31:0] mmem[64];
    int          n_wr = 0;
    int          n_rd = 0;

    // Slave delay knobs: >=0 fixed cycles, <0 random.
    int aw_lat = 0, w_lat = 0, ar_lat = 0;
    int b_lat = 0, r_lat = 0, rsp_lat = 0;

    // ---------------- slave model ----------------
    logic [31:0] smem[64];
    bit          aw_got, w_got, ar_got, b_armed, r_armed, b_hsp, r_hsp;
    int          aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
    int          b_count = 0, r_count = 0;
    int          aw_rd = 0, w_rd = 0, ar_rd = 0;
    logic [31:0] aw_a, ar_a, w_d;
    logic [3:0]  w_s;
    bit          aw_hold, w_hold, ar_hold;
    logic [31:0] aw_prev, ar_prev;
    logic [35:0] w_prev;

    initial begin
        for (int i = 0; i < 64; i++) begin
            smem[i] = '0;
            mmem[i] = '0;
        end
    end

    always @(negedge aclk) begin
        if (!aresetn) begin
            awready = 0; wready = 0; arready = 0;
            bvalid = 0; rvalid = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            b_armed = 0; r_armed = 0; b_hsp = 0; r_hsp = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
            aw_hold = 0; w_hold = 0; ar_hold = 0;
            aw_rd = aw_exp.size();
            w_rd = w_exp.size();
            ar_rd = ar_exp.size();
        end else begin
            // write path
            if (b_hsp) begin
                bvalid = 0; b_hsp = 0; b_armed = 0;
                aw_got = 0; w_got = 0; b_count++;
            end
            if (aw_hold)
                chk(awvalid && awaddr == aw_prev, "aw_stable",
                    {31'd0, awvalid, awaddr}, {32'd1, aw_prev});
            aw_hold = 0;
            if (aw_got) begin
                awready = 0;
                chk(!awvalid, "aw_after_hs", 64'(awvalid), 64'd0);
            end else if (awvalid) begin
                awready = rdy(aw_lat, aw_wait);
                aw_wait++;
                if (awready) begin
                    aw_got = 1; aw_a = awaddr; aw_wait = 0;
                    if (aw_rd < aw_exp.size()) begin
                        chk(awaddr == aw_exp[aw_rd], "awaddr",
                            64'(awaddr), 64'(aw_exp[aw_rd]));
                        aw_rd++;
                    end else chk(0, "aw_unexpected", 64'(awaddr), 64'd0);
                    chk(awprot == 3'b000, "awprot", 64'(awprot), 64'd0);
                end else begin
                    aw_hold = 1; aw_prev = awaddr;
                end
            end else begin
                awready = 0; aw_wait = 0;
            end

            if (w_hold)
                chk(wvalid && {wstrb, wdata} == w_prev, "w_stable",
                    {27'd0, wvalid, wstrb, wdata}, {28'd1, w_prev});
            w_hold = 0;
            if (w_got) begin
                wready = 0;
                chk(!wvalid, "w_after_hs", 64'(wvalid), 64'd0);
            end else if (wvalid) begin
                wready = rdy(w_lat, w_wait);
                w_wait++;
                if (wready) begin
                    w_got = 1; w_d = wdata; w_s = wstrb; w_wait = 0;
                    if (w_rd < w_exp.size()) begin
                        chk({wstrb, wdata} == w_exp[w_rd], "wdata",
                            64'({wstrb, wdata}), 64'(w_exp[w_rd]));
                        w_rd++;
                    end else chk(0, "w_unexpected", 64'(wdata), 64'd0);
                end else begin
                    w_hold = 1; w_prev = {wstrb, wdata};
                end
            end else begin
                wready = 0; w_wait = 0;
            end

            if (bready)
                chk(aw_got && w_got, "bready_early",
                    {aw_got, w_got}, 64'd3);
            if (aw_got && w_got && !b_armed) begin
                b_armed = 1;
                b_cnt = (b_lat < 0) ? int'($urandom_range(0, 3)) : b_lat;
            end
            if (b_armed && !bvalid) begin
                if (b_cnt == 0) begin
                    bvalid = 1;
                    bresp = resp_of(aw_a);
                    smem[idx_of(aw_a)] = merge(smem[idx_of(aw_a)], w_d, w_s);
                end else b_cnt--;
            end
            if (bvalid && bready) b_hsp = 1;

            // read path
            if (r_hsp) begin
                rvalid = 0; r_hsp = 0; r_armed = 0;
                ar_got = 0; r_count++;
            end
            if (ar_hold)
                chk(arvalid && araddr == ar_prev, "ar_stable",
                    {31'd0, arvalid, araddr}, {32'd1, ar_prev});
            ar_hold = 0;
            if (ar_got) begin
                arready = 0;
                chk(!arvalid, "ar_after_hs", 64'(arvalid), 64'd0);
            end else if (arvalid) begin
                arready = rdy(ar_lat, ar_wait);
                ar_wait++;
                if (arready) begin
                    ar_got = 1; ar_a = araddr; ar_wait = 0;
                    if (ar_rd < ar_exp.size()) begin
                        chk(araddr == ar_exp[ar_rd], "araddr",
                            64'(araddr), 64'(ar_exp[ar_rd]));
                        ar_rd++;
                    end else chk(0, "ar_unexpected", 64'(araddr), 64'd0);
                    chk(arprot == 3'b000, "arprot", 64'(arprot), 64'd0);
                end else begin
                    ar_hold = 1; ar_prev = araddr;
                end
            end else begin
                arready = 0; ar_wait = 0;
            end

            if (rready)
                chk(ar_got, "rready_early", 64'(ar_got), 64'd1);
            if (ar_got && !r_armed) begin
                r_armed = 1;
                r_cnt = (r_lat < 0) ? int'($urandom_range(0, 3)) : r_lat;
            end
            if (r_armed && !rvalid) begin
                if (r_cnt == 0) begin
                    rvalid = 1;
                    rdata = smem[idx_of(ar_a)];
                    rresp = resp_of(ar_a);
                end else r_cnt--;
            end
            if (rvalid && rready) r_hsp = 1;
        end
    end

    // ---------------- response monitor ----------------
    bit          busy = 0;
    bit          rsp_hold = 0;
    logic [34:0] rsp_prev;
    int          rsp_wait = 0;
    int          rsp_rd = 0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            busy = 0; rsp_hold = 0; rsp_ready = 0; rsp_wait = 0;
            rsp_rd = rsp_q.size();
        end else begin
            chk(cmd_ready == !busy, "cmd_ready", 64'(cmd_ready), 64'(!busy));
            if (rsp_hold)
                chk(rsp_valid && {rsp_write, rsp_resp, rsp_rdata} == rsp_prev,
                    "rsp_stable", {rsp_valid, rsp_write, rsp_resp, rsp_rdata},
                    {1'b1, rsp_prev});
            rsp_hold = 0;
            if (rsp_valid) begin
                if (!busy) chk(0, "rsp_spurious", 64'd1, 64'd0);
                rsp_ready = rdy(rsp_lat, rsp_wait);
                rsp_wait++;
                if (rsp_ready) begin
                    rsp_wait = 0;
                    if (rsp_rd < rsp_q.size()) begin
                        chk({rsp_write, rsp_resp, rsp_rdata} ==
                            {rsp_q[rsp_rd].wr, rsp_q[rsp_rd].resp,
                             rsp_q[rsp_rd].rdata}, "rsp",
                            {rsp_write, rsp_resp, rsp_rdata},
                            {rsp_q[rsp_rd].wr, rsp_q[rsp_rd].resp,
                             rsp_q[rsp_rd].rdata});
                        rsp_rd++;
                    end else chk(0, "rsp_unexpected", 64'(rsp_rdata), 64'd0);
                    busy = 0;
                end else begin
                    rsp_hold = 1;
                    rsp_prev = {rsp_write, rsp_resp, rsp_rdata};
                end
            end else begin
                rsp_ready = (rsp_lat < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                rsp_wait = 0;
            end
            if (cmd_valid && cmd_ready) busy = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        bit          acc;
        logic [31:0] al;
        rsp_t        e;
        al = {a[31:2], 2'b00};
        @(posedge aclk); #1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s;
        acc = 0;
        for (int n = 0; n < 2000 && !acc; n++) begin
            @(negedge aclk);
            if (cmd_ready) acc = 1;
        end
        if (!acc) begin
            chk(0, "cmd_accept_timeout", 64'd0, 64'd1);
            cmd_valid = 0;
            return;
        end
        e.wr = wr;
        e.resp = resp_of(al);
        if (wr) begin
            mmem[idx_of(al)] = merge(mmem[idx_of(al)], d, s);
            e.rdata = '0;
            aw_exp.push_back(al);
            w_exp.push_back({s, d});
            n_wr++;
        end else begin
            e.rdata = mmem[idx_of(al)];
            ar_exp.push_back(al);
            n_rd++;
        end
        rsp_q.push_back(e);
        @(posedge aclk); #1;
        cmd_valid = 0;
        cmd_write = 1'($urandom);
        cmd_addr = $urandom;
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);
        @(negedge aclk);
        if (wr) begin
            chk(awvalid && wvalid, "wr_launch", {awvalid, wvalid}, 64'd3);
            chk(awaddr == al && wdata == d && wstrb == s, "wr_payload",
                {wstrb, awaddr, wdata}, {s, al, d});
        end else begin
            chk(arvalid, "rd_launch", 64'(arvalid), 64'd1);
            chk(araddr == al, "rd_addr", 64'(araddr), 64'(al));
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge aclk);
            if (!busy && rsp_rd == rsp_q.size()) done = 1;
        end
        chk(done, "idle_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        int          b0;
        int          ix;
        logic [31:0] saved;

        #3;
        chk(!awvalid && !wvalid && !arvalid && !bready && !rready &&
            !rsp_valid, "reset_valids",
            {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 64'd0);
        chk(awaddr == 0 && wdata == 0 && rsp_rdata == 0 && rsp_resp == 0,
            "reset_regs", {awaddr, rsp_rdata}, 64'd0);
        #20 aresetn = 1;

        // write, slave ready immediately, OKAY
        issue(1, 32'h10, 32'hDEADBEEF, 4'hF);
        wait_idle();

        // wready 3 cycles ahead of awready, SLVERR, one B handshake
        aw_lat = 3; w_lat = 0;
        b0 = b_count;
        issue(1, 32'h210, 32'hA5A5_0F0F, 4'h5);
        wait_idle();
        chk(b_count == b0 + 1, "one_b", 64'(b_count - b0), 64'd1);
        aw_lat = 0;

        // read 0x23 with 5-cycle rvalid delay
        r_lat = 5;
        issue(0, 32'h23, '0, '0);
        wait_idle();
        r_lat = 0;

        // errored read with response back-pressure
        rsp_lat = 10;
        issue(0, 32'h313, '0, '0);
        wait_idle();
        rsp_lat = 0;

        // zero strobes are issued unchanged
        issue(1, 32'h10, 32'h0, 4'h0);
        issue(0, 32'h10, '0, '0);
        wait_idle();

        // reset while AW is pending
        aw_lat = 100;
        ix = idx_of(32'h44);
        saved = mmem[ix];
        issue(1, 32'h44, 32'h1234_5678, 4'hF);
        @(posedge aclk); #2;
        chk(awvalid, "rst_pre_aw", 64'(awvalid), 64'd1);
        aresetn = 0;
        #1;
        chk(!awvalid && !wvalid && !rsp_valid && !bready,
            "rst_async_drop", {awvalid, wvalid, rsp_valid, bready}, 64'd0);
        mmem[ix] = saved;
        n_wr--;
        repeat (2) @(posedge aclk);
        #3 aresetn = 1;
        @(negedge aclk);
        chk(cmd_ready, "rst_cmd_ready", 64'(cmd_ready), 64'd1);
        aw_lat = 0;
        issue(0, 32'h44, '0, '0);
        wait_idle();

        // random back-to-back traffic against random-ready slave
        aw_lat = -1; w_lat = -1; ar_lat = -1;
        b_lat = -1; r_lat = -1; rsp_lat = -1;
        for (int i = 0; i < 100; i++) begin
            issue(1'($urandom_range(0, 1)), $urandom, $urandom,
                  4'($urandom_range(0, 15)));
        end
        wait_idle();

        chk(b_count == n_wr, "b_total", 64'(b_count), 64'(n_wr));
        chk(r_count == n_rd, "r_total", 64'(r_count), 64'(n_rd));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
